// File: rtl/alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one ALU between two requesters. Arbitrates round-robin
//             (or fixed priority, see below), accepts one operation at a time
//             through a valid/ready handshake, and drives the ALU from
//             registered operands. It waits ALU_LAT cycles, then presents a
//             tagged result on a valid/ready response port.
//  Ports    : CLOCK_50, reset                 clock, sync active-high reset
//             req{0,1}_valid/_ready/_a/_b/_op requester handshakes + operands
//             rsp_valid/_ready/_id/_data      tagged result handshake
//             alu_a/_b/_op -> ALU, alu_o <- ALU
//             busy                            high whenever FSM is not idle
//  Config   : `define ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins
//             when both requesters are valid). Round-robin otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
   parameter int WORD_SIZE = 16,
   parameter int ALU_LAT   = 0
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [WORD_SIZE-1:0] req0_a,
   input  logic [WORD_SIZE-1:0] req0_b,
   input  logic [2:0]           req0_op,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [WORD_SIZE-1:0] req1_a,
   input  logic [WORD_SIZE-1:0] req1_b,
   input  logic [2:0]           req1_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [WORD_SIZE-1:0] rsp_data,
   output logic [WORD_SIZE-1:0] alu_a,
   output logic [WORD_SIZE-1:0] alu_b,
   output logic [2:0]           alu_op,
   input  logic [WORD_SIZE-1:0] alu_o,
   output logic                 busy
);

   // Counter must be at least one bit even for a combinational ALU.
   localparam int                CNT_W    = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
   localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(ALU_LAT);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic                   r_last_grant;
   logic [CNT_W-1:0]       r_cnt;
   logic [WORD_SIZE-1:0]   r_op_a;
   logic [WORD_SIZE-1:0]   r_op_b;
   logic [2:0]             r_op_op;
   logic                   r_rsp_valid;
   logic                   r_rsp_id;
   logic [WORD_SIZE-1:0]   r_rsp_data;

   logic                   w_grant;
   logic                   w_accept;
   logic                   w_req0_ready;
   logic                   w_req1_ready;
   logic [WORD_SIZE-1:0]   w_sel_a;
   logic [WORD_SIZE-1:0]   w_sel_b;
   logic [2:0]             w_sel_op;

   // Grant is only meaningful when at least one requester is valid; the
   // accept qualifier below masks it otherwise.
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign w_grant = ~req0_valid;
`else
   assign w_grant = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
`endif

   assign w_sel_a  = w_grant ? req1_a  : req0_a;
   assign w_sel_b  = w_grant ? req1_b  : req0_b;
   assign w_sel_op = w_grant ? req1_op : req0_op;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and handshake outputs. Readies are forced low while
   // reset is asserted so nothing is accepted on a reset edge.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_req0_ready = 1'b0;
      w_req1_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!reset) begin
               w_req0_ready = req0_valid & ~w_grant;
               w_req1_ready = req1_valid &  w_grant;
            end
            w_accept = w_req0_ready | w_req1_ready;
            if (w_accept) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: operand capture, latency counter, response registers.
   // Operand registers are written only on accept, so the ALU inputs stay
   // stable for the whole operation and hold afterwards.
   // ------------------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_op      <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         if (w_accept) begin
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_op_op      <= w_sel_op;
            r_rsp_id     <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= LAT_INIT;
         end
         if (r_state == S_EXEC) begin
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - CNT_ONE;
            end else begin
               r_rsp_data  <= alu_o;
               r_rsp_valid <= 1'b1;
            end
         end
         if ((r_state == S_RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign req0_ready = w_req0_ready;
   assign req1_ready = w_req1_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_data   = r_rsp_data;
   assign alu_a      = r_op_a;
   assign alu_b      = r_op_b;
   assign alu_op     = r_op_op;
   assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. Main instance uses
//             ALU_LAT=1; two extra instances cover ALU_LAT=0 and ALU_LAT=3.
//             The external ALU is modelled here (op0 add, op1 sub, op2 and,
//             op3 or, op4 xor, others 0) with a pipeline matching ALU_LAT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         default: return '0;
      endcase
   endfunction

   // ---------------- main DUT, ALU_LAT = 1 ----------------
   logic          req0_valid = 0, req1_valid = 0, rsp_ready = 1;
   logic          req0_ready, req1_ready, rsp_valid, rsp_id, busy;
   logic [W-1:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [2:0]    req0_op = 0, req1_op = 0;
   logic [W-1:0]  rsp_data, alu_a, alu_b, alu_o;
   logic [2:0]    alu_op;

   always @(posedge clk) alu_o <= alu_f(alu_a, alu_b, alu_op);

   alu_arbiter #(.WORD_SIZE(W), .ALU_LAT(1)) dut (
      .CLOCK_50(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_o(alu_o), .busy(busy)
   );

   // ---------------- ALU_LAT = 0 instance (req0 only) ----------------
   logic          l0_valid = 0, l0_ready, l0_r1_ready, l0_rsp_valid, l0_rsp_id, l0_busy;
   logic          l0_zero1 = 0, l0_rsp_ready = 1;
   logic [W-1:0]  l0_a = 0, l0_b = 0, l0_zw = 0, l0_rsp_data, l0_alu_a, l0_alu_b, l0_alu_o;
   logic [2:0]    l0_op = 0, l0_z3 = 0, l0_alu_op;

   assign l0_alu_o = alu_f(l0_alu_a, l0_alu_b, l0_alu_op);

   alu_arbiter #(.WORD_SIZE(W), .ALU_LAT(0)) dut_l0 (
      .CLOCK_50(clk), .reset(reset),
      .req0_valid(l0_valid), .req0_ready(l0_ready), .req0_a(l0_a), .req0_b(l0_b), .req0_op(l0_op),
      .req1_valid(l0_zero1), .req1_ready(l0_r1_ready), .req1_a(l0_zw), .req1_b(l0_zw), .req1_op(l0_z3),
      .rsp_valid(l0_rsp_valid), .rsp_ready(l0_rsp_ready), .rsp_id(l0_rsp_id), .rsp_data(l0_rsp_data),
      .alu_a(l0_alu_a), .alu_b(l0_alu_b), .alu_op(l0_alu_op), .alu_o(l0_alu_o), .busy(l0_busy)
   );

   // ---------------- ALU_LAT = 3 instance (req1 only) ----------------
   logic          l3_valid = 0, l3_ready, l3_r0_ready, l3_rsp_valid, l3_rsp_id, l3_busy;
   logic          l3_zero0 = 0, l3_rsp_ready = 1;
   logic [W-1:0]  l3_a = 0, l3_b = 0, l3_zw = 0, l3_rsp_data, l3_alu_a, l3_alu_b;
   logic [W-1:0]  l3_p1, l3_p2, l3_p3;
   logic [2:0]    l3_op = 0, l3_z3 = 0, l3_alu_op;

   always @(posedge clk) begin
      l3_p1 <= alu_f(l3_alu_a, l3_alu_b, l3_alu_op);
      l3_p2 <= l3_p1;
      l3_p3 <= l3_p2;
   end

   alu_arbiter #(.WORD_SIZE(W), .ALU_LAT(3)) dut_l3 (
      .CLOCK_50(clk), .reset(reset),
      .req0_valid(l3_zero0), .req0_ready(l3_r0_ready), .req0_a(l3_zw), .req0_b(l3_zw), .req0_op(l3_z3),
      .req1_valid(l3_valid), .req1_ready(l3_ready), .req1_a(l3_a), .req1_b(l3_b), .req1_op(l3_op),
      .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_id(l3_rsp_id), .rsp_data(l3_rsp_data),
      .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_op(l3_alu_op), .alu_o(l3_p3), .busy(l3_busy)
   );

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // One isolated transaction on the main DUT with rsp_ready=1.
   task automatic do_txn(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic [W-1:0] exp);
      int n;
      int k;
      if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
      else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 10) begin step(); n++; end
      chk("txn_accept", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
      chk("txn_other_ready", {31'd0, id ? req0_ready : req1_ready}, 32'd0);
      step();
      req0_valid = 0;
      req1_valid = 0;
      chk("txn_busy", {31'd0, busy}, 32'd1);
      chk("txn_alu_a", {16'd0, alu_a}, {16'd0, a});
      k = 1;
      while (!rsp_valid && k < 20) begin step(); k++; end
      chk("txn_latency", k, 3);
      chk("txn_data", {16'd0, rsp_data}, {16'd0, exp});
      chk("txn_id", {31'd0, rsp_id}, {31'd0, id});
      step();
      chk("txn_idle_after", {30'd0, busy, rsp_valid}, 32'd0);
   endtask

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   op;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n;
      int k;
      int acc_n;
      logic acc_id[4];
      int acc_cyc[4];
      logic exp_order[4];
      int l3_cyc[3];
      logic [W-1:0] sa[3], sb[3], sres[3];
      logic [2:0] sop[3];
      int held_bad;

      vecs[0] = '{1'b0, 16'd5,      16'd3,      3'd0, 16'd8};
      vecs[1] = '{1'b1, 16'd9,      16'd4,      3'd1, 16'd5};
      vecs[2] = '{1'b0, 16'hFFFF,   16'h0001,   3'd0, 16'h0000};
      vecs[3] = '{1'b1, 16'h0000,   16'h0001,   3'd1, 16'hFFFF};
      vecs[4] = '{1'b0, 16'h1234,   16'h0F0F,   3'd2, 16'h0204};
      vecs[5] = '{1'b1, 16'h00F0,   16'h0F00,   3'd3, 16'h0FF0};
      vecs[6] = '{1'b0, 16'hAAAA,   16'hFFFF,   3'd4, 16'h5555};
      vecs[7] = '{1'b1, 16'h8000,   16'h8000,   3'd0, 16'h0000};

      // ---- reset state, with a requester waiting during reset ----
      reset = 1;
      req0_valid = 1; req0_a = 16'd7; req0_b = 16'd7;
      step();
      step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      chk("rst_alu_ops", {alu_a[12:0], alu_b, alu_op}, 32'd0);
      chk("rst_ready_held", {30'd0, req0_ready, req1_ready}, 32'd0);
      req0_valid = 0;
      reset = 0;

      // ---- table-driven single transactions (entry 0 is the basic case) ----
      for (int i = 0; i < 8; i++) begin
         do_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
      end

      // ---- continuous contention ----
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      do_reset();
      req0_valid = 1; req0_a = 16'd1; req0_b = 16'd2; req0_op = 3'd0;
      req1_valid = 1; req1_a = 16'd3; req1_b = 16'd4; req1_op = 3'd0;
      #1;
      acc_n = 0;
      for (int c = 0; c < 30 && acc_n < 4; c++) begin
         if (req0_ready && req1_ready) chk("both_ready", 32'd1, 32'd0);
         if (req0_ready || req1_ready) begin
            acc_id[acc_n] = req1_ready;
            acc_cyc[acc_n] = c;
            acc_n++;
         end
         step();
      end
      req0_valid = 0;
      req1_valid = 0;
      chk("rr_accepts", acc_n, 4);
      for (int i = 0; i < 4; i++) begin
         if (i < acc_n) begin
            chk("rr_order", {31'd0, acc_id[i]}, {31'd0, exp_order[i]});
            if (i > 0) chk("rr_interval", acc_cyc[i] - acc_cyc[i-1], 4);
         end
      end
      n = 0;
      while (busy && n < 20) begin step(); n++; end
      chk("rr_drain", {31'd0, busy}, 32'd0);

      // ---- response back-pressure ----
      rsp_ready = 0;
      req1_valid = 1; req1_a = 16'd9; req1_b = 16'd4; req1_op = 3'd1;
      #1;
      n = 0;
      while (!req1_ready && n < 10) begin step(); n++; end
      chk("bp_accept", {31'd0, req1_ready}, 32'd1);
      step();
      req1_valid = 0;
      req0_valid = 1; req0_a = 16'd1; req0_b = 16'd1; req0_op = 3'd0;
      n = 0;
      while (!rsp_valid && n < 10) begin step(); n++; end
      for (int c = 0; c < 10; c++) begin
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_data", {16'd0, rsp_data}, 32'd5);
         chk("bp_id", {31'd0, rsp_id}, 32'd1);
         chk("bp_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
         step();
      end
      rsp_ready = 1;
      step();
      chk("bp_release_busy", {31'd0, busy}, 32'd0);
      chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_data_holds", {16'd0, rsp_data}, 32'd5);
      chk("bp_req0_ready_idle", {31'd0, req0_ready}, 32'd1);
      req0_valid = 0;
      #1;
      chk("valid_drop_no_ready", {31'd0, req0_ready}, 32'd0);
      step();
      chk("valid_drop_no_accept", {31'd0, busy}, 32'd0);

      // ---- reset during EXEC ----
      req0_valid = 1; req0_a = 16'd1; req0_b = 16'd2; req0_op = 3'd0;
      #1;
      n = 0;
      while (!req0_ready && n < 10) begin step(); n++; end
      step();
      req0_valid = 0;
      chk("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1;
      step();
      reset = 0;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_data", {16'd0, rsp_data}, 32'd0);
      held_bad = 0;
      for (int c = 0; c < 8; c++) begin
         if (rsp_valid !== 1'b0) held_bad++;
         step();
      end
      chk("mid_no_response", held_bad, 0);
      req0_valid = 1;
      req1_valid = 1;
      #1;
      chk("mid_grant_req0", {30'd0, req0_ready, req1_ready}, 32'd2);
      req0_valid = 0;
      req1_valid = 0;
      step();

      // ---- ALU_LAT=0 instance ----
      l0_valid = 1; l0_a = 16'hFFFF; l0_b = 16'h0001; l0_op = 3'd0;
      #1;
      n = 0;
      while (!l0_ready && n < 10) begin step(); n++; end
      chk("l0_accept", {31'd0, l0_ready}, 32'd1);
      step();
      l0_valid = 0;
      k = 1;
      while (!l0_rsp_valid && k < 20) begin step(); k++; end
      chk("l0_latency", k, 2);
      chk("l0_data", {16'd0, l0_rsp_data}, 32'd0);
      chk("l0_id", {31'd0, l0_rsp_id}, 32'd0);

      // ---- ALU_LAT=3 instance, back-to-back on req1 ----
      sa[0] = 16'd3;     sb[0] = 16'd4; sop[0] = 3'd0; sres[0] = 16'd7;
      sa[1] = 16'd10;    sb[1] = 16'd3; sop[1] = 3'd1; sres[1] = 16'd7;
      sa[2] = 16'h0100;  sb[2] = 16'd1; sop[2] = 3'd0; sres[2] = 16'h0101;
      l3_valid = 1; l3_a = sa[0]; l3_b = sb[0]; l3_op = sop[0];
      #1;
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (!l3_ready && n < 20) begin step(); n++; end
         chk("l3_accept", {31'd0, l3_ready}, 32'd1);
         l3_cyc[i] = cyc;
         step();
         if (i < 2) begin
            l3_a = sa[i+1]; l3_b = sb[i+1]; l3_op = sop[i+1];
         end else begin
            l3_valid = 0;
         end
         held_bad = 0;
         k = 1;
         while (!l3_rsp_valid && k < 20) begin
            if (l3_alu_a !== sa[i] || l3_alu_b !== sb[i] || l3_alu_op !== sop[i]) held_bad++;
            step();
            k++;
         end
         chk("l3_operands_stable", held_bad, 0);
         chk("l3_latency", k, 5);
         chk("l3_data", {16'd0, l3_rsp_data}, {16'd0, sres[i]});
         chk("l3_id", {31'd0, l3_rsp_id}, 32'd1);
         step();
      end
      chk("l3_interval_a", l3_cyc[1] - l3_cyc[0], 6);
      chk("l3_interval_b", l3_cyc[2] - l3_cyc[1], 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
